// File: rtl/sync_filter.sv
// Multi-channel input synchroniser with a per-channel consecutive-sample glitch
// filter and registered single-cycle rise/fall pulses.
module sync_filter #(
  parameter int unsigned      WIDTH   = 4,
  parameter int unsigned      FLOPS   = 2,
  parameter int unsigned      FILTER  = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int unsigned CNT_W = $clog2(FILTER + 1);

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_filter: WIDTH must be at least 1");
  end
  if (FLOPS < 2) begin : g_bad_flops
    $error("sync_filter: FLOPS must be at least 2");
  end
  if (FILTER < 1) begin : g_bad_filter
    $error("sync_filter: FILTER must be at least 1");
  end

  logic [FLOPS-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]            s;

  logic [WIDTH-1:0]            level_q, level_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;
  logic                        changed_q, changed_d;

  // Plain flop chain, stage 0 at the low end; no logic between stages.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {FLOPS{RST_VAL}};
    end else begin
      sync_q <= {sync_q[FLOPS-2:0], data_in};
    end
  end

  assign s = sync_q[FLOPS-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q   <= RST_VAL;
      cnt_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  // A new level is accepted only after FILTER consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(FILTER - 1)) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
        rise_d[i]  = s[i] & ~level_q[i];
        fall_d[i]  = ~s[i] & level_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  assign sync_out = level_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_sync_filter.sv
// Directed self-checking bench for sync_filter: default instance plus a
// FLOPS=3 / FILTER=1 / RST_VAL=1111 instance.
module tb_sync_filter;

  logic       clk;
  logic       rstn;
  logic [3:0] d_in, d_sync, d_rise, d_fall;
  logic       d_chg;
  logic [3:0] p_in, p_sync, p_rise, p_fall;
  logic       p_chg;

  int passed = 0;
  int total  = 0;

  sync_filter u_dflt (
    .clk     (clk),
    .rstn    (rstn),
    .data_in (d_in),
    .sync_out(d_sync),
    .rise    (d_rise),
    .fall    (d_fall),
    .changed (d_chg)
  );

  sync_filter #(
    .WIDTH  (4),
    .FLOPS  (3),
    .FILTER (1),
    .RST_VAL(4'b1111)
  ) u_param (
    .clk     (clk),
    .rstn    (rstn),
    .data_in (p_in),
    .sync_out(p_sync),
    .rise    (p_rise),
    .fall    (p_fall),
    .changed (p_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    p_in = 4'b1111;
    for (int e = 0; e < 6; e++) begin
      d_in = 4'(e * 5 + 3);
      step();
      total++;
      if ({d_sync, d_rise, d_fall, d_chg} !== 13'b0) begin
        $display("FAIL reset_hold e=%0d got sync=%b rise=%b fall=%b chg=%b want all 0",
                 e, d_sync, d_rise, d_fall, d_chg);
      end else passed++;
      total++;
      if ({p_sync, p_rise, p_fall, p_chg} !== {4'b1111, 9'b0}) begin
        $display("FAIL reset_hold_param e=%0d got sync=%b rise=%b fall=%b chg=%b want sync=1111",
                 e, p_sync, p_rise, p_fall, p_chg);
      end else passed++;
    end
    d_in = 4'b0000;
    rstn = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      total++;
      if ({d_sync, d_rise, d_fall, d_chg} !== 13'b0) begin
        $display("FAIL reset_release e=%0d got sync=%b rise=%b fall=%b chg=%b want all 0",
                 e, d_sync, d_rise, d_fall, d_chg);
      end else passed++;
      total++;
      if ({p_sync, p_rise, p_fall, p_chg} !== {4'b1111, 9'b0}) begin
        $display("FAIL reset_release_param e=%0d got sync=%b rise=%b fall=%b chg=%b want sync=1111",
                 e, p_sync, p_rise, p_fall, p_chg);
      end else passed++;
    end
  endtask

  // data_in[0] 0->1 is accepted at edge 10, then 1->0 likewise.
  task automatic test_clean_step();
    logic [3:0] es, er, ef;
    logic       ec;
    d_in = 4'b0001;
    for (int e = 1; e <= 11; e++) begin
      step();
      es = (e >= 10) ? 4'b0001 : 4'b0000;
      er = (e == 10) ? 4'b0001 : 4'b0000;
      ef = 4'b0000;
      ec = (e == 10);
      total++;
      if ({d_sync, d_rise, d_fall, d_chg} !== {es, er, ef, ec}) begin
        $display("FAIL clean_rise e=%0d got sync=%b rise=%b fall=%b chg=%b want sync=%b rise=%b fall=%b chg=%b",
                 e, d_sync, d_rise, d_fall, d_chg, es, er, ef, ec);
      end else passed++;
    end
    d_in = 4'b0000;
    for (int e = 1; e <= 11; e++) begin
      step();
      es = (e >= 10) ? 4'b0000 : 4'b0001;
      er = 4'b0000;
      ef = (e == 10) ? 4'b0001 : 4'b0000;
      ec = (e == 10);
      total++;
      if ({d_sync, d_rise, d_fall, d_chg} !== {es, er, ef, ec}) begin
        $display("FAIL clean_fall e=%0d got sync=%b rise=%b fall=%b chg=%b want sync=%b rise=%b fall=%b chg=%b",
                 e, d_sync, d_rise, d_fall, d_chg, es, er, ef, ec);
      end else passed++;
    end
  endtask

  // Input high for plen cycles: 7 is rejected, 8 is accepted at edge 10 and
  // its return low is accepted 8 edges later at edge 18.
  task automatic test_glitch();
    logic [3:0] es, er, ef;
    logic       ec;
    for (int plen = 7; plen <= 8; plen++) begin
      d_in = 4'b0010;
      for (int e = 1; e <= 20; e++) begin
        step();
        if (e == plen) d_in = 4'b0000;
        es = (plen == 8 && e >= 10 && e < 18) ? 4'b0010 : 4'b0000;
        er = (plen == 8 && e == 10) ? 4'b0010 : 4'b0000;
        ef = (plen == 8 && e == 18) ? 4'b0010 : 4'b0000;
        ec = (plen == 8 && (e == 10 || e == 18));
        total++;
        if ({d_sync, d_rise, d_fall, d_chg} !== {es, er, ef, ec}) begin
          $display("FAIL glitch len=%0d e=%0d got sync=%b rise=%b fall=%b chg=%b want sync=%b rise=%b fall=%b chg=%b",
                   plen, e, d_sync, d_rise, d_fall, d_chg, es, er, ef, ec);
        end else passed++;
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] es, er, ef;
    logic       ec;
    d_in = 4'b1000;
    for (int e = 1; e <= 12; e++) step();
    total++;
    if ({d_sync, d_rise, d_fall, d_chg} !== {4'b1000, 9'b0}) begin
      $display("FAIL simul_settle got sync=%b rise=%b fall=%b chg=%b want sync=1000",
               d_sync, d_rise, d_fall, d_chg);
    end else passed++;
    d_in = 4'b0100;
    for (int e = 1; e <= 11; e++) begin
      step();
      es = (e >= 10) ? 4'b0100 : 4'b1000;
      er = (e == 10) ? 4'b0100 : 4'b0000;
      ef = (e == 10) ? 4'b1000 : 4'b0000;
      ec = (e == 10);
      total++;
      if ({d_sync, d_rise, d_fall, d_chg} !== {es, er, ef, ec}) begin
        $display("FAIL simul e=%0d got sync=%b rise=%b fall=%b chg=%b want sync=%b rise=%b fall=%b chg=%b",
                 e, d_sync, d_rise, d_fall, d_chg, es, er, ef, ec);
      end else passed++;
    end
    d_in = 4'b0000;
    for (int e = 1; e <= 12; e++) step();
    total++;
    if ({d_sync, d_rise, d_fall, d_chg} !== 13'b0) begin
      $display("FAIL simul_clear got sync=%b rise=%b fall=%b chg=%b want all 0",
               d_sync, d_rise, d_fall, d_chg);
    end else passed++;
  endtask

  // Count reaches 5 after edge 7, reset held over edge 8; restart needs 10 more edges.
  task automatic test_reset_mid();
    logic [3:0] es, er;
    logic       ec;
    d_in = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      step();
      total++;
      if ({d_sync, d_rise, d_fall, d_chg} !== 13'b0) begin
        $display("FAIL rstmid_pre e=%0d got sync=%b rise=%b fall=%b chg=%b want all 0",
                 e, d_sync, d_rise, d_fall, d_chg);
      end else passed++;
    end
    rstn = 1'b0;
    #1;
    total++;
    if ({d_sync, d_rise, d_fall, d_chg} !== 13'b0) begin
      $display("FAIL rstmid_assert got sync=%b rise=%b fall=%b chg=%b want all 0",
               d_sync, d_rise, d_fall, d_chg);
    end else passed++;
    step();
    total++;
    if ({d_sync, d_rise, d_fall, d_chg} !== 13'b0) begin
      $display("FAIL rstmid_hold got sync=%b rise=%b fall=%b chg=%b want all 0",
               d_sync, d_rise, d_fall, d_chg);
    end else passed++;
    rstn = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      step();
      es = (e >= 10) ? 4'b0001 : 4'b0000;
      er = (e == 10) ? 4'b0001 : 4'b0000;
      ec = (e == 10);
      total++;
      if ({d_sync, d_rise, d_fall, d_chg} !== {es, er, 4'b0000, ec}) begin
        $display("FAIL rstmid_post e=%0d got sync=%b rise=%b fall=%b chg=%b want sync=%b rise=%b fall=0000 chg=%b",
                 e, d_sync, d_rise, d_fall, d_chg, es, er, ec);
      end else passed++;
    end
    d_in = 4'b0000;
    for (int e = 1; e <= 12; e++) step();
  endtask

  // FLOPS=3, FILTER=1: step accepted at edge 4; a one-cycle pulse passes through.
  task automatic test_param();
    logic [3:0] es, er, ef;
    logic       ec;
    p_in = 4'b1110;
    for (int e = 1; e <= 5; e++) begin
      step();
      es = (e >= 4) ? 4'b1110 : 4'b1111;
      ef = (e == 4) ? 4'b0001 : 4'b0000;
      ec = (e == 4);
      total++;
      if ({p_sync, p_rise, p_fall, p_chg} !== {es, 4'b0000, ef, ec}) begin
        $display("FAIL param_step e=%0d got sync=%b rise=%b fall=%b chg=%b want sync=%b rise=0000 fall=%b chg=%b",
                 e, p_sync, p_rise, p_fall, p_chg, es, ef, ec);
      end else passed++;
    end
    p_in = 4'b1111;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 1) p_in = 4'b1110;
      es = (e == 4) ? 4'b1111 : 4'b1110;
      er = (e == 4) ? 4'b0001 : 4'b0000;
      ef = (e == 5) ? 4'b0001 : 4'b0000;
      ec = (e == 4 || e == 5);
      total++;
      if ({p_sync, p_rise, p_fall, p_chg} !== {es, er, ef, ec}) begin
        $display("FAIL param_pulse e=%0d got sync=%b rise=%b fall=%b chg=%b want sync=%b rise=%b fall=%b chg=%b",
                 e, p_sync, p_rise, p_fall, p_chg, es, er, ef, ec);
      end else passed++;
    end
  endtask

  initial begin
    d_in = 4'b0000;
    p_in = 4'b1111;
    rstn = 1'b0;
    test_reset();
    test_clean_step();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_param();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sync_filter.md
Name: sync_filter

Overview:
- Multi-channel successor to the single-bit 2-flop synchroniser.
- Brings WIDTH independent asynchronous inputs (buttons, jack-detect, codec status pins) into the clk domain through a parametrised flop chain.
- Per channel, adds a consecutive-sample glitch filter and registered single-cycle rise/fall pulses.
- Sits between the board I/O pins and the control/register logic.

Parameters:
- WIDTH, 4, number of independent channels.
- FLOPS, 2, synchroniser stages per channel; minimum 2.
- FILTER, 8, consecutive cycles a new level must persist at the synchroniser output before it is accepted; minimum 1.
- RST_VAL, 0, WIDTH-bit reset value for every sync stage and for sync_out; bit i applies to channel i.

Ports:
- clk, input, 1, system clock.
- rstn, input, 1, asynchronous active-low reset.
- data_in, input, WIDTH, asynchronous raw inputs.
- sync_out, output, WIDTH, filtered, synchronised level.
- rise, output, WIDTH, one-cycle pulse when sync_out[i] goes 0->1.
- fall, output, WIDTH, one-cycle pulse when sync_out[i] goes 1->0.
- changed, output, 1, OR of all rise and fall bits; registered, same cycle as the pulses.

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk.
- Reset values: all sync stages[i] = RST_VAL[i]; sync_out = RST_VAL; counters = 0; rise, fall, changed = 0.
- No pulse on reset assertion, during reset, or on the first edge after release.

Per channel i, fully independent:

Sync chain:
- stage0 <= data_in[i]; stage k <= stage k-1.
- s = last stage, giving FLOPS-edge latency.
- No logic between stages.

Filter (state = level L = sync_out[i], counter cnt, width clog2(FILTER+1)):
- s == L: cnt <= 0; L holds.
- s != L and cnt < FILTER-1: cnt <= cnt+1; L holds.
- s != L and cnt == FILTER-1: L <= s; cnt <= 0. This is the accept edge.
- FILTER=1: L updates on the first edge where s != L.
- A disagreement that lasts fewer than FILTER consecutive edges is discarded: cnt clears and L is unchanged.
- cnt never exceeds FILTER-1; no saturation logic is required.

Latency:
- An input held stable from sampling edge 1 appears on sync_out after edge FLOPS+FILTER.
- With defaults that is edge 10.

Pulses:
- On the accept edge, rise[i] <= s & ~L and fall[i] <= ~s & L; both are 0 on every other edge.
- Each pulse is high for exactly one cycle, coincident with the first cycle sync_out shows the new value.
- rise[i] and fall[i] are never high together.

changed:
- changed <= |(next rise | next fall), so it aligns with the pulses.

Simultaneous events:
- Channels accepting on the same edge each pulse independently; changed is a single 1.

Reset mid-operation:
- Asynchronously clears in-progress counts.
- After release, filtering restarts from RST_VAL with cnt = 0.

Parameter checks:
- FLOPS < 2, FILTER < 1, or WIDTH < 1 cause an elaboration-time error.

Test Plan:
- Reset: hold rstn=0 with data_in toggling -> sync_out = RST_VAL, rise/fall/changed = 0 throughout and on the first 10 edges after release (data_in static = RST_VAL).
- Clean step, defaults: data_in[0] 0->1, sampled first at edge N -> sync_out[0]=1 after edge N+9; rise[0]=1 and changed=1 for exactly that one cycle; fall=0; other channels unchanged.
- Glitch rejection, defaults: data_in[1] high for 7 cycles, then low -> sync_out[1] stays 0, no pulses. Repeat with 8 cycles -> sync_out[1] goes 1 on the 8th cycle of s high, rise[1] pulses. Then data_in[1] returns low -> fall[1] pulses FLOPS+FILTER edges later.
- Simultaneous channels: data_in[2] 0->1 and data_in[3] 1->0 (after settling) on the same edge -> rise[2] and fall[3] on the same cycle, changed=1 for one cycle only.
- Reset mid-count: data_in[0] high for 5 post-sync cycles, assert rstn for 1 cycle, keep data_in[0] high -> no pulse before release; after release, acceptance occurs a full FLOPS+FILTER edges later.
- Parameter sweep: FLOPS=3, FILTER=1, RST_VAL=4'b1111, WIDTH=4 -> outputs reset to 1111; data_in[0] 1->0 gives fall[0] after edge 4; 1-cycle input pulses are still passed (FILTER=1).
